// File: rtl/throw_hit_if.sv
// Handshake/bus bundle between the throw stimulus side and throw_hit_ctl.
// The master drives the throw, position and target; the slave reports the result.
interface throw_hit_if;
  logic        throw_start;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [11:0] target_x;
  logic [11:0] target_y;
  logic        score_clr;
  logic        busy;
  logic        hit;
  logic        miss;
  logic [7:0]  score;

  modport master (
    output throw_start, x_pos, y_pos, target_x, target_y, score_clr,
    input  busy, hit, miss, score
  );

  modport slave (
    input  throw_start, x_pos, y_pos, target_x, target_y, score_clr,
    output busy, hit, miss, score
  );
endinterface

// File: rtl/throw_hit_ctl.sv
// Judges each throw as a hit on a rectangular target or a miss (ground, off-screen, timeout)
// and keeps a saturating hit score for the HUD.
//
//   state  | meaning
//   IDLE   | waiting for throw_start, target latched on acceptance
//   ARM    | 2 cycles so positions from the previous throw are never judged
//   FLIGHT | judging the registered position every cycle, timeout running
//   HIT    | one-cycle hit pulse, score bumps on exit
//   MISS   | one-cycle miss pulse
//   COOL   | HOLD_CYCLES cooldown before re-arming
module throw_hit_ctl #(
  parameter int unsigned TARGET_W    = 64,
  parameter int unsigned TARGET_H    = 32,
  parameter int unsigned GROUND_Y    = 700,
  parameter int unsigned SCREEN_W    = 1024,
  parameter int unsigned TIMEOUT     = 3000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic       clk,
  input logic       rst_n,
  throw_hit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, FLIGHT, HIT, MISS, COOL} state_t;

  localparam int unsigned TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ARM_LOAD    = TMR_W'(1);
  localparam logic [TMR_W-1:0] FLIGHT_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD   = TMR_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [11:0]      x_q, y_q;
  logic [11:0]      tx_l, ty_l;
  logic             in_tgt_d, out_d;
  logic             in_tgt_q, out_q;
  logic             busy_q, hit_q, miss_q;
  logic [7:0]       score_q;
  logic [12:0]      x_lo, x_hi, y_lo, y_hi;

  assign bus.busy  = busy_q;
  assign bus.hit   = hit_q;
  assign bus.miss  = miss_q;
  assign bus.score = score_q;

  // 13-bit bounds so a target parked near 4095 cannot wrap its far edge
  always_comb begin
    x_lo     = {1'b0, tx_l};
    y_lo     = {1'b0, ty_l};
    x_hi     = x_lo + 13'(TARGET_W - 1);
    y_hi     = y_lo + 13'(TARGET_H - 1);
    in_tgt_d = ({1'b0, x_q} >= x_lo) && ({1'b0, x_q} <= x_hi) &&
               ({1'b0, y_q} >= y_lo) && ({1'b0, y_q} <= y_hi);
    out_d    = ({1'b0, y_q} >= 13'(GROUND_Y)) || ({1'b0, x_q} >= 13'(SCREEN_W));
  end

  // position register plus one stage of registered verdicts: position at edge k is judged at k+2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      in_tgt_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      x_q      <= bus.x_pos;
      y_q      <= bus.y_pos;
      in_tgt_q <= in_tgt_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      tx_l    <= '0;
      ty_l    <= '0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;

      if (bus.score_clr)
        score_q <= '0;
      else if (state == HIT && score_q != 8'hFF)
        score_q <= score_q + 8'd1;

      case (state)
        IDLE: begin
          if (bus.throw_start) begin
            tx_l   <= bus.target_x;
            ty_l   <= bus.target_y;
            tmr    <= ARM_LOAD;
            busy_q <= 1'b1;
            state  <= ARM;
          end
        end
        ARM: begin
          if (tmr == '0) begin
            tmr   <= FLIGHT_LOAD;
            state <= FLIGHT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        FLIGHT: begin
          // hit outranks ground/off-screen and timeout in the same cycle
          if (in_tgt_q) begin
            hit_q <= 1'b1;
            state <= HIT;
          end else if (out_q || tmr == '0) begin
            miss_q <= 1'b1;
            state  <= MISS;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        HIT, MISS: begin
          tmr   <= COOL_LOAD;
          state <= COOL;
        end
        COOL: begin
          if (tmr == '0) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_throw_hit_ctl.sv
// Self-checking bench for throw_hit_ctl: constant-position vector table, hand-built corner
// sequences and randomized flight paths, all judged by a path-level reference model.
module tb_throw_hit_ctl;

  localparam int TW = 64, TH = 32, GY = 700, SW = 1024, TO = 3000, HOLD = 16;
  localparam int R_MISS = 0, R_HIT = 1, R_NONE = 2;

  typedef struct {
    int tx, ty, x, y, res, off;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   score_m;
  int   px[$];
  int   py[$];

  throw_hit_if bus();

  throw_hit_ctl #(
    .TARGET_W(TW), .TARGET_H(TH), .GROUND_Y(GY), .SCREEN_W(SW),
    .TIMEOUT(TO), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Path-level model: point j is sampled at throw edge + 1 + j and judged two edges later,
  // the first judgement landing at offset 3; TIMEOUT judgements at most.
  function automatic void model(input int tx, input int ty, output int res, output int off);
    int x, y;
    res = R_MISS;
    off = TO + 2;
    for (int j = 0; j < TO; j++) begin
      x = (j < px.size()) ? px[j] : px[px.size()-1];
      y = (j < py.size()) ? py[j] : py[py.size()-1];
      if (x >= tx && x <= tx + TW - 1 && y >= ty && y <= ty + TH - 1) begin
        res = R_HIT; off = 3 + j; return;
      end
      if (y >= GY || x >= SW) begin
        res = R_MISS; off = 3 + j; return;
      end
    end
  endfunction

  task automatic run_throw(input string tag, input int tx, input int ty,
                           input bit inject_start, input bit clr_on_hit, input bit scramble);
    int exp_res, exp_off, got_res, got_off, pulses, both, end_off, idx;
    model(tx, ty, exp_res, exp_off);
    got_res = R_NONE; got_off = -1; pulses = 0; both = 0; end_off = -1;
    bus.target_x    = 12'(tx);
    bus.target_y    = 12'(ty);
    bus.throw_start = 1'b1;
    tick;
    check({tag, " busy_on_accept"}, int'(bus.busy), 1);
    bus.throw_start = 1'b0;
    bus.x_pos = 12'(px[0]);
    bus.y_pos = 12'(py[0]);
    for (int n = 1; n <= exp_off + HOLD + 10; n++) begin
      tick;
      if (bus.hit && bus.miss) both++;
      if (bus.hit || bus.miss) begin
        pulses++;
        if (got_res == R_NONE) begin
          got_res = bus.hit ? R_HIT : R_MISS;
          got_off = n;
        end
      end
      bus.score_clr   = clr_on_hit && bus.hit;
      bus.throw_start = inject_start && (n == 50);
      idx = (n < px.size()) ? n : px.size() - 1;
      bus.x_pos = 12'(px[idx]);
      bus.y_pos = 12'(py[idx]);
      if (scramble) begin
        bus.target_x = 12'($urandom_range(0, 4095));
        bus.target_y = 12'($urandom_range(0, 4095));
      end
      if (!bus.busy) begin
        end_off = n;
        break;
      end
    end
    bus.score_clr   = 1'b0;
    bus.throw_start = 1'b0;
    if (clr_on_hit) score_m = 0;
    else if (exp_res == R_HIT && score_m < 255) score_m++;
    check({tag, " result"},  got_res, exp_res);
    check({tag, " latency"}, got_off, exp_off);
    check({tag, " pulses"},  pulses, 1);
    check({tag, " hit_and_miss"}, both, 0);
    check({tag, " busy_release"}, end_off, exp_off + 1 + HOLD);
    check({tag, " score"}, int'(bus.score), score_m);
  endtask

  initial begin
    vec_t tbl[9];
    int   tx, ty, len, pulses;

    vectors = 0; miscompares = 0; score_m = 0;
    bus.throw_start = 1'b0; bus.score_clr = 1'b0;
    bus.x_pos = '0; bus.y_pos = '0; bus.target_x = '0; bus.target_y = '0;

    tbl[0] = '{500,  400,  563,  431,  R_HIT,  3};
    tbl[1] = '{500,  400,  500,  400,  R_HIT,  3};
    tbl[2] = '{500,  400,  0,    700,  R_MISS, 3};
    tbl[3] = '{500,  400,  1024, 300,  R_MISS, 3};
    tbl[4] = '{500,  400,  600,  700,  R_MISS, 3};
    tbl[5] = '{4060, 4080, 4095, 4095, R_HIT,  3};
    tbl[6] = '{10,   680,  20,   700,  R_HIT,  3};
    tbl[7] = '{10,   690,  73,   721,  R_HIT,  3};
    tbl[8] = '{10,   690,  74,   721,  R_MISS, 3};

    rst_n = 1'b0;
    #100;
    check("reset busy",  int'(bus.busy), 0);
    check("reset hit",   int'(bus.hit), 0);
    check("reset miss",  int'(bus.miss), 0);
    check("reset score", int'(bus.score), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) begin
      int r, o;
      px = {tbl[i].x}; py = {tbl[i].y};
      model(tbl[i].tx, tbl[i].ty, r, o);
      check($sformatf("tbl%0d model_res", i), r, tbl[i].res);
      check($sformatf("tbl%0d model_off", i), o, tbl[i].off);
      run_throw($sformatf("tbl%0d", i), tbl[i].tx, tbl[i].ty, 1'b0, 1'b0, 1'b0);
    end

    px = {100, 205, 310, 415, 520}; py = {600, 552, 505, 457, 410};
    run_throw("direct_hit", 500, 400, 1'b0, 1'b0, 1'b1);

    px = {564, 564}; py = {431, 700};
    run_throw("edge_then_ground", 500, 400, 1'b0, 1'b0, 1'b0);

    px = {10}; py = {10};
    run_throw("timeout", 500, 400, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      tx  = $urandom_range(0, 900);
      ty  = $urandom_range(0, 650);
      len = $urandom_range(1, 30);
      px = {}; py = {};
      for (int i = 0; i < len; i++) begin
        if (i == len - 1 && $urandom_range(0, 1) == 0) begin
          px.push_back($urandom_range(0, 1100));
          py.push_back(GY + $urandom_range(0, 50));
        end else if (i == len - 1 || $urandom_range(0, 3) == 0) begin
          px.push_back(tx + $urandom_range(0, TW - 1));
          py.push_back(ty + $urandom_range(0, TH - 1));
        end else begin
          px.push_back($urandom_range(0, 1100));
          py.push_back($urandom_range(0, 760));
        end
      end
      run_throw($sformatf("rand%0d", r), tx, ty, 1'b0, 1'b0, 1'b1);
    end

    px = {520}; py = {410};
    for (int i = 0; i < 256; i++) run_throw($sformatf("sat%0d", i), 500, 400, 1'b0, 1'b0, 1'b0);
    check("score saturated", int'(bus.score), 255);
    run_throw("clr_on_hit", 500, 400, 1'b0, 1'b1, 1'b0);

    px = {10}; py = {10};
    bus.x_pos = 12'd10; bus.y_pos = 12'd10;
    bus.target_x = 12'd500; bus.target_y = 12'd400;
    run_throw("pre_abort_hit", 0, 0, 1'b0, 1'b0, 1'b0);
    bus.x_pos = 12'd10; bus.y_pos = 12'd10;
    bus.target_x = 12'd500; bus.target_y = 12'd400;
    bus.throw_start = 1'b1;
    tick;
    bus.throw_start = 1'b0;
    repeat (20) tick;
    check("abort busy_before", int'(bus.busy), 1);
    #4;
    rst_n = 1'b0;
    #1;
    check("abort busy",  int'(bus.busy), 0);
    check("abort hit",   int'(bus.hit), 0);
    check("abort miss",  int'(bus.miss), 0);
    check("abort score", int'(bus.score), 0);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick;
      if (bus.hit || bus.miss || bus.busy) pulses++;
    end
    check("abort quiet_after", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
